// File: rtl/mips_io_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_io_pkg
// Purpose  : Shared types and sizing helpers for the MIPS port I/O bridge.
// Revision : 1.0
// ============================================================================
package mips_io_pkg;

    localparam int c_def_bus_width = 16;
    localparam int c_drop_cnt_w    = 8;

    typedef enum logic [0:0] {
        RX_EMPTY = 1'b0,
        RX_HELD  = 1'b1
    } rx_state_t;

    // Pointer width for a power-of-two depth; count needs one extra bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_io_bridge_io_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : io_sync_fifo
// Purpose  : Show-ahead synchronous FIFO carrying processor port writes.
// Revision : 1.0
// ============================================================================
module io_sync_fifo
    import mips_io_pkg::*;
#(
    parameter int BUS_WIDTH  = c_def_bus_width,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_wr_en,
    input  logic [BUS_WIDTH-1:0] i_wr_data,
    input  logic                 i_rd_ready,
    output logic [BUS_WIDTH-1:0] o_rd_data,
    output logic                 o_rd_valid,
    output logic                 o_full,
    output logic                 o_pop
);

    localparam int c_ptr_w = ptr_width(FIFO_DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [BUS_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_cnt_w-1:0]   r_count;
    logic                 w_push;
    logic                 w_pop;

    assign o_rd_valid = (r_count != '0);
    assign o_full     = (r_count == c_cnt_w'(FIFO_DEPTH));
    assign w_pop      = o_rd_valid && i_rd_ready;
    // A pop frees a slot in the same edge, so a write into a full FIFO is kept.
    assign w_push     = i_wr_en && (!o_full || w_pop);
    assign o_pop      = w_pop;
    assign o_rd_data  = o_rd_valid ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mips_io_bridge.sv
`default_nettype none
// ============================================================================
// Module   : mips_io_bridge
// Purpose  : Peripheral endpoint of the processor port bus: output FIFO plus
//            one-word input holding register. MIPS_IO_DROP_CNT_EN adds drop_cnt.
// Revision : 1.0
// ============================================================================
module mips_io_bridge
    import mips_io_pkg::*;
#(
    parameter int BUS_WIDTH  = c_def_bus_width,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BUS_WIDTH-1:0]    cpu_out_data,
    input  logic                    cpu_out_en,
    output logic [BUS_WIDTH-1:0]    cpu_in_data,
    output logic                    cpu_in_valid,
    input  logic                    cpu_in_rd,
    output logic [BUS_WIDTH-1:0]    ext_tx_data,
    output logic                    ext_tx_valid,
    input  logic                    ext_tx_ready,
    input  logic [BUS_WIDTH-1:0]    ext_rx_data,
    input  logic                    ext_rx_valid,
    output logic                    ext_rx_ready,
    output logic                    out_full,
`ifdef MIPS_IO_DROP_CNT_EN
    output logic [c_drop_cnt_w-1:0] drop_cnt,
`endif
    output logic                    out_overflow
);

    logic                 w_pop;
    logic                 w_drop;
    logic                 r_overflow;
    rx_state_t            r_rx_state;
    rx_state_t            w_rx_next;
    logic                 w_rx_load;
    logic [BUS_WIDTH-1:0] r_hold;

    io_sync_fifo #(
        .BUS_WIDTH  (BUS_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_wr_en    (cpu_out_en),
        .i_wr_data  (cpu_out_data),
        .i_rd_ready (ext_tx_ready),
        .o_rd_data  (ext_tx_data),
        .o_rd_valid (ext_tx_valid),
        .o_full     (out_full),
        .o_pop      (w_pop)
    );

    assign w_drop       = cpu_out_en && out_full && !w_pop;
    assign out_overflow = r_overflow;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

`ifdef MIPS_IO_DROP_CNT_EN
    logic [c_drop_cnt_w-1:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != '1)) begin
            r_drop_cnt <= r_drop_cnt + c_drop_cnt_w'(1);
        end
    end

    assign drop_cnt = r_drop_cnt;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rx_state <= RX_EMPTY;
            r_hold     <= '0;
        end else begin
            r_rx_state <= w_rx_next;
            if (w_rx_load) begin
                r_hold <= ext_rx_data;
            end
        end
    end

    // Releasing the register costs a cycle: no refill in the read cycle.
    always_comb begin
        w_rx_next    = r_rx_state;
        w_rx_load    = 1'b0;
        ext_rx_ready = 1'b0;
        cpu_in_valid = 1'b0;
        case (r_rx_state)
            RX_EMPTY: begin
                ext_rx_ready = 1'b1;
                if (ext_rx_valid) begin
                    w_rx_load = 1'b1;
                    w_rx_next = RX_HELD;
                end
            end
            RX_HELD: begin
                cpu_in_valid = 1'b1;
                if (cpu_in_rd) begin
                    w_rx_next = RX_EMPTY;
                end
            end
            default: w_rx_next = RX_EMPTY;
        endcase
    end

    assign cpu_in_data = r_hold;

endmodule
`default_nettype wire

// File: tb/tb_mips_io_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_io_bridge
// Purpose  : Directed self-checking bench for mips_io_bridge.
// Revision : 1.0
// ============================================================================
module tb_mips_io_bridge;
    import mips_io_pkg::*;

    localparam int c_bw = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [c_bw-1:0] cpu_out_data;
    logic            cpu_out_en;
    logic [c_bw-1:0] cpu_in_data;
    logic            cpu_in_valid;
    logic            cpu_in_rd;
    logic [c_bw-1:0] ext_tx_data;
    logic            ext_tx_valid;
    logic            ext_tx_ready;
    logic [c_bw-1:0] ext_rx_data;
    logic            ext_rx_valid;
    logic            ext_rx_ready;
    logic            out_full;
    logic            out_overflow;
`ifdef MIPS_IO_DROP_CNT_EN
    logic [c_drop_cnt_w-1:0] drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_io_bridge #(
        .BUS_WIDTH  (c_bw),
        .FIFO_DEPTH (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cpu_out_data (cpu_out_data),
        .cpu_out_en   (cpu_out_en),
        .cpu_in_data  (cpu_in_data),
        .cpu_in_valid (cpu_in_valid),
        .cpu_in_rd    (cpu_in_rd),
        .ext_tx_data  (ext_tx_data),
        .ext_tx_valid (ext_tx_valid),
        .ext_tx_ready (ext_tx_ready),
        .ext_rx_data  (ext_rx_data),
        .ext_rx_valid (ext_rx_valid),
        .ext_rx_ready (ext_rx_ready),
        .out_full     (out_full),
`ifdef MIPS_IO_DROP_CNT_EN
        .drop_cnt     (drop_cnt),
`endif
        .out_overflow (out_overflow)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk16(input string tag, input logic [c_bw-1:0] obs, input logic [c_bw-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    logic [c_bw-1:0] exp_q [4];

    initial begin
        rst          = 1'b0;
        cpu_out_data = '0;
        cpu_out_en   = 1'b0;
        cpu_in_rd    = 1'b0;
        ext_tx_ready = 1'b0;
        ext_rx_data  = '0;
        ext_rx_valid = 1'b0;

        // Reset state
        step();
        step();
        chk1 ("rst_tx_valid", ext_tx_valid, 1'b0);
        chk16("rst_tx_data",  ext_tx_data,  16'h0000);
        chk1 ("rst_full",     out_full,     1'b0);
        chk1 ("rst_rx_ready", ext_rx_ready, 1'b1);
        chk1 ("rst_in_valid", cpu_in_valid, 1'b0);
        chk1 ("rst_overflow", out_overflow, 1'b0);
        chk16("rst_in_data",  cpu_in_data,  16'h0000);
`ifdef MIPS_IO_DROP_CNT_EN
        chk16("rst_drop_cnt", {8'h00, drop_cnt}, 16'h0000);
`endif
        rst = 1'b1;
        step();

        // Output ordering
        cpu_out_en = 1'b1; cpu_out_data = 16'h1111;
        step();
        chk1 ("ord_valid_lat", ext_tx_valid, 1'b1);
        chk16("ord_head0",     ext_tx_data,  16'h1111);
        cpu_out_data = 16'h2222;
        step();
        cpu_out_data = 16'h3333;
        step();
        cpu_out_en = 1'b0;
        chk16("ord_head_hold", ext_tx_data, 16'h1111);
        ext_tx_ready = 1'b1;
        step();
        chk16("ord_head1", ext_tx_data, 16'h2222);
        step();
        chk16("ord_head2", ext_tx_data, 16'h3333);
        step();
        chk1 ("ord_empty_valid", ext_tx_valid, 1'b0);
        chk16("ord_empty_data",  ext_tx_data,  16'h0000);
        ext_tx_ready = 1'b0;

        // Fill to full, then overflow
        cpu_out_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cpu_out_data = 16'hA000 + 16'(i);
            step();
        end
        chk1("ovf_full",       out_full,     1'b1);
        chk1("ovf_not_yet",    out_overflow, 1'b0);
        cpu_out_data = 16'hA004;
        step();
        cpu_out_en = 1'b0;
        chk1("ovf_flag",       out_overflow, 1'b1);
        chk1("ovf_still_full", out_full,     1'b1);
`ifdef MIPS_IO_DROP_CNT_EN
        chk16("ovf_drop_cnt", {8'h00, drop_cnt}, 16'h0001);
`endif
        ext_tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk16("ovf_drain", ext_tx_data, 16'hA000 + 16'(i));
            step();
        end
        chk1("ovf_drained", ext_tx_valid, 1'b0);
        ext_tx_ready = 1'b0;

        // Full with simultaneous pop and push
        cpu_out_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cpu_out_data = 16'hC000 + 16'(i);
            step();
        end
        cpu_out_data = 16'hBEEF;
        ext_tx_ready = 1'b1;
        step();
        cpu_out_en = 1'b0;
        chk1("pp_full_kept", out_full, 1'b1);
        exp_q[0] = 16'hC001; exp_q[1] = 16'hC002;
        exp_q[2] = 16'hC003; exp_q[3] = 16'hBEEF;
        for (int i = 0; i < 4; i++) begin
            chk16("pp_drain", ext_tx_data, exp_q[i]);
            step();
        end
        chk1("pp_drained",  ext_tx_valid, 1'b0);
        chk1("pp_sticky",   out_overflow, 1'b1);
`ifdef MIPS_IO_DROP_CNT_EN
        chk16("pp_no_drop", {8'h00, drop_cnt}, 16'h0001);
`endif
        ext_tx_ready = 1'b0;

        // Input handshake
        ext_rx_valid = 1'b1; ext_rx_data = 16'h5A5A;
        chk1("in_ready_idle", ext_rx_ready, 1'b1);
        step();
        chk1 ("in_valid",   cpu_in_valid, 1'b1);
        chk16("in_data0",   cpu_in_data,  16'h5A5A);
        chk1 ("in_busy",    ext_rx_ready, 1'b0);
        ext_rx_data = 16'h6B6B;
        step();
        chk16("in_held_off", cpu_in_data, 16'h5A5A);
        cpu_in_rd = 1'b1;
        step();
        cpu_in_rd = 1'b0;
        chk1 ("in_released", cpu_in_valid, 1'b0);
        chk1 ("in_ready2",   ext_rx_ready, 1'b1);
        chk16("in_keep",     cpu_in_data,  16'h5A5A);
        step();
        ext_rx_valid = 1'b0;
        chk1 ("in_valid2", cpu_in_valid, 1'b1);
        chk16("in_data1",  cpu_in_data,  16'h6B6B);
        cpu_in_rd = 1'b1;
        step();
        step();
        cpu_in_rd = 1'b0;
        chk1 ("in_rd_ignored", cpu_in_valid, 1'b0);
        chk16("in_keep2",      cpu_in_data,  16'h6B6B);

        // Reset mid-operation
        cpu_out_en = 1'b1; cpu_out_data = 16'h7777;
        step();
        cpu_out_data = 16'h8888;
        step();
        cpu_out_en = 1'b0;
        ext_rx_valid = 1'b1; ext_rx_data = 16'h9999;
        step();
        ext_rx_valid = 1'b0;
        chk1("mid_tx_valid", ext_tx_valid, 1'b1);
        chk1("mid_in_valid", cpu_in_valid, 1'b1);
        rst = 1'b0;
        step();
        chk1 ("mrst_tx_valid", ext_tx_valid, 1'b0);
        chk16("mrst_tx_data",  ext_tx_data,  16'h0000);
        chk1 ("mrst_full",     out_full,     1'b0);
        chk1 ("mrst_overflow", out_overflow, 1'b0);
        chk1 ("mrst_in_valid", cpu_in_valid, 1'b0);
        chk16("mrst_in_data",  cpu_in_data,  16'h0000);
        chk1 ("mrst_rx_ready", ext_rx_ready, 1'b1);
`ifdef MIPS_IO_DROP_CNT_EN
        chk16("mrst_drop_cnt", {8'h00, drop_cnt}, 16'h0000);
`endif
        rst = 1'b1;
        step();
        chk1("post_rst_empty", ext_tx_valid, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
